// File: rtl/serial_rx_ctrl_pkg.sv
// Shared types and defaults for the serial receive control stage.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN
    } state_e;

    localparam int unsigned SYNC_LEN_DEF  = 16;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
    localparam int unsigned NIB_W         = 4;

endpackage

// File: rtl/serial_rx_ctrl_if.sv
// Bit-stream input and frame-buffer control bundle of serial_rx_ctrl.
interface serial_rx_ctrl_if #(
    parameter int unsigned NDATA_LOG = 7
);
    logic                 en;
    logic                 bit_in;
    logic                 bit_vld;
    logic                 sr_din;
    logic                 sr_ena;
    logic [NDATA_LOG-1:0] sr_cnt;
    logic                 nib_vld;
    logic                 frame_done;
    logic                 sync_err;
    logic                 ovr;
    logic                 busy;

    modport master (
        output en, bit_in, bit_vld,
        input  sr_din, sr_ena, sr_cnt, nib_vld, frame_done, sync_err, ovr, busy
    );

    modport slave (
        input  en, bit_in, bit_vld,
        output sr_din, sr_ena, sr_cnt, nib_vld, frame_done, sync_err, ovr, busy
    );
endinterface

// File: rtl/serial_rx_ctrl_sync_detect.sv
// Sliding sync-word detector; match is asserted combinationally for the bit that completes the word.
module sync_detect
    import serial_pkg::*;
#(
    parameter int unsigned         SYNC_LEN  = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic shift_i,
    input  logic bit_i,
    output logic match_o
);
    // Only SYNC_LEN-1 bits of history are kept; the incoming bit completes the window.
    logic [SYNC_LEN-2:0] hist_q, hist_d;
    logic [SYNC_LEN-1:0] window;

    assign window  = {hist_q, bit_i};
    assign match_o = shift_i && (window == SYNC_WORD);

    always_comb begin
        hist_d = hist_q;
        if (clr_i) begin
            hist_d = '0;
        end else if (shift_i) begin
            hist_d = window[SYNC_LEN-2:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/serial_rx_ctrl.sv
// Sync hunt, payload forwarding and latch/nibble-rotate drain control for the serial frame buffer.
module serial_rx_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned         NDATA     = 128,
    parameter int unsigned         SYNC_LEN  = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int unsigned         TIMEOUT   = 255
) (
    input logic             clk,
    input logic             rst,
    serial_rx_ctrl_if.slave bus
);
    localparam int unsigned NDATA_LOG = $clog2(NDATA);
    localparam int unsigned GAP_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned NIB_LOG   = $clog2(NIB_W);

    localparam logic [NDATA_LOG:0]   BCNT_LAST = (NDATA_LOG + 1)'(NDATA - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(TIMEOUT - 1);
    localparam logic [NDATA_LOG-1:0] CNT_IDLE  = NDATA_LOG'(1);
    localparam logic [NIB_LOG-1:0]   NIB_PHASE = NIB_LOG'(1);

    state_e               state_q, state_d;
    logic [NDATA_LOG:0]   bcnt_q, bcnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NDATA_LOG-1:0] sr_cnt_q, sr_cnt_d;
    logic                 sr_din_q, sr_din_d;
    logic                 sr_ena_q, sr_ena_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sync_err_q, sync_err_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 hunt_shift, sync_clr, sync_match;

    assign hunt_shift = (state_q == ST_HUNT) && bus.en && bus.bit_vld;

    sync_detect #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (sync_clr),
        .shift_i (hunt_shift),
        .bit_i   (bus.bit_in),
        .match_o (sync_match)
    );

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        gap_d        = gap_q;
        sr_cnt_d     = CNT_IDLE;
        sr_din_d     = sr_din_q;
        sr_ena_d     = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        ovr_d        = 1'b0;
        sync_clr     = 1'b0;
        if (!bus.en) begin
            state_d  = ST_IDLE;
            sync_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (sync_match) begin
                        state_d = ST_LOAD;
                        bcnt_d  = '0;
                        gap_d   = '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.bit_vld) begin
                        sr_din_d = bus.bit_in;
                        sr_ena_d = 1'b1;
                        gap_d    = '0;
                        if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_LAST) state_d = ST_FLUSH;
                    end else if (gap_q >= GAP_LAST) begin
                        sync_err_d = 1'b1;
                        sync_clr   = 1'b1;
                        state_d    = ST_HUNT;
                    end else if (gap_q != '1) begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    ovr_d    = bus.bit_vld;
                    sr_cnt_d = '0;
                    state_d  = ST_DRAIN;
                end
                ST_DRAIN: begin
                    ovr_d = bus.bit_vld;
                    if (sr_cnt_q == '1) begin
                        frame_done_d = 1'b1;
                        sync_clr     = 1'b1;
                        state_d      = ST_HUNT;
                    end else begin
                        sr_cnt_d = sr_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_LOAD) || (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bcnt_q       <= '0;
            gap_q        <= '0;
            sr_cnt_q     <= CNT_IDLE;
            sr_din_q     <= 1'b0;
            sr_ena_q     <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            ovr_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            gap_q        <= gap_d;
            sr_cnt_q     <= sr_cnt_d;
            sr_din_q     <= sr_din_d;
            sr_ena_q     <= sr_ena_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            ovr_q        <= ovr_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.sr_din     = sr_din_q;
    assign bus.sr_ena     = sr_ena_q;
    assign bus.sr_cnt     = sr_cnt_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.ovr        = ovr_q;
    assign bus.busy       = busy_q;
    assign bus.nib_vld    = (state_q == ST_DRAIN) && (sr_cnt_q[NIB_LOG-1:0] == NIB_PHASE);

endmodule
